// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions used by the fetch stage: opcode encodings, NOP word and
// branch condition codes.
package instr_fetch_pkg;

  typedef enum logic [3:0] {
    OP_NOPER = 4'b0000,
    OP_B     = 4'b0100
  } opcode_e;

  localparam logic [31:0] NOP_WORD    = 32'h0;
  localparam logic [2:0]  COND_ALWAYS = 3'b111;

  function automatic logic is_branch_always(logic [3:0] opcode, logic [2:0] cond);
    return (opcode == OP_B) && (cond == COND_ALWAYS);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer with push/pop/flush. Invalid slots are held at zero so the
// head register can drive decode directly (NOP when empty).
module fetch_fifo #(
  parameter int unsigned W = 52
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic [W-1:0] head_nxt_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    count_d  = count_q;
    if (flush_i) begin
      mem_d[0] = '0;
      mem_d[1] = '0;
      count_d  = 2'd0;
    end else begin
      if (pop_i && (count_q != 2'd0)) begin
        mem_d[0] = mem_q[1];
        mem_d[1] = '0;
        count_d  = count_q - 2'd1;
      end
      if (push_i && (count_d != 2'd2)) begin
        if (count_d == 2'd0) mem_d[0] = din_i;
        else                 mem_d[1] = din_i;
        count_d = count_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      count_q  <= count_d;
    end
  end

  assign head_o     = mem_q[0];
  assign head_nxt_o = mem_d[0];
  assign count_o    = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC walk, request issue, 2-entry fetch buffer, redirect
// flush/drop. Define FETCH_STATIC_PREDICT_EN to self-redirect on always-taken branches.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ImemReq,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic              ImemReady,
  input  logic              ImemValid,
  input  logic [31:0]       ImemData,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic [31:0]       Instruction,
  output logic [ADDR_W-1:0] InstrPC,
  output logic              PredTaken
);

  localparam int unsigned W = 32 + ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        outst_q, outst_d;
  logic [1:0]        drop_q, drop_d;
  logic [ADDR_W-1:0] tag_q [2];
  logic [ADDR_W-1:0] tag_d [2];
  logic [W-1:0]      head, head_nxt;
  logic [1:0]        count;
  logic              pop, push, redirect, hs;
  logic [ADDR_W-1:0] redirect_pc;
  logic [1:0]        occ_eff;
  logic [2:0]        inflight;
  logic              unused_head_nxt;

  assign pop = !Stall && (count != 2'd0);

`ifdef FETCH_STATIC_PREDICT_EN
  logic pred_q;
  logic pred_hit;

  assign pred_hit        = pop && is_branch_always(head[W-1 -: 4], head[W-5 -: 3]);
  assign redirect        = BranchTaken || pred_hit;
  assign redirect_pc     = BranchTaken ? BranchTarget : head[ADDR_W +: ADDR_W];
  assign PredTaken       = pred_q;
  assign unused_head_nxt = ^head_nxt[W-8:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pred_q <= 1'b0;
    else      pred_q <= is_branch_always(head_nxt[W-1 -: 4], head_nxt[W-5 -: 3]);
  end
`else
  assign redirect        = BranchTaken;
  assign redirect_pc     = BranchTarget;
  assign PredTaken       = 1'b0;
  assign unused_head_nxt = ^head_nxt;
`endif

  // A head leaving this cycle frees its slot, so a 1-cycle memory sustains one word per cycle.
  assign occ_eff  = count - {1'b0, pop};
  assign inflight = {1'b0, occ_eff} + {1'b0, outst_q};
  assign ImemReq  = rst && (inflight < 3'd2) && !redirect;
  assign ImemAddr = pc_q;
  assign hs       = ImemReq && ImemReady;
  assign push     = ImemValid && (drop_q == 2'd0) && !redirect;

  always_comb begin
    tag_d[0] = tag_q[0];
    tag_d[1] = tag_q[1];
    if (ImemValid) tag_d[0] = tag_q[1];
    if (hs) begin
      if ((outst_q - {1'b0, ImemValid}) == 2'd0) tag_d[0] = pc_q;
      else                                       tag_d[1] = pc_q;
    end

    outst_d = outst_q + {1'b0, hs} - {1'b0, ImemValid};

    // Every response still owed after a redirect belongs to the old stream.
    if (redirect)                           drop_d = outst_d;
    else if (ImemValid && (drop_q != 2'd0)) drop_d = drop_q - 2'd1;
    else                                    drop_d = drop_q;

    if (redirect) pc_d = redirect_pc;
    else if (hs)  pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    else          pc_d = pc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      outst_q  <= 2'd0;
      drop_q   <= 2'd0;
      tag_q[0] <= '0;
      tag_q[1] <= '0;
    end else begin
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      tag_q[0] <= tag_d[0];
      tag_q[1] <= tag_d[1];
    end
  end

  fetch_fifo #(.W(W)) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst),
    .push_i     (push),
    .pop_i      (pop),
    .flush_i    (redirect),
    .din_i      ({ImemData, tag_q[0]}),
    .head_o     (head),
    .head_nxt_o (head_nxt),
    .count_o    (count)
  );

  assign Instruction = head[W-1:ADDR_W];
  assign InstrPC     = head[ADDR_W-1:0];

  assert property (@(posedge clk) (outst_q != 2'd3) && (drop_q != 2'd3));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized traffic, checked
// against a queue-based model of the fetch buffer and outstanding requests.
module tb_instr_fetch;

  localparam int unsigned       ADDR_W   = 20;
  localparam logic [31:0]       MEM_BASE = 32'h1000_0000;
  localparam logic [ADDR_W-1:0] BR_ADDR  = 20'h00200;
  localparam logic [31:0]       BR_WORD  = 32'h4E00_0040;
`ifdef FETCH_STATIC_PREDICT_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ImemReq;
  logic [ADDR_W-1:0] ImemAddr;
  logic              ImemReady = 1'b0;
  logic              ImemValid = 1'b0;
  logic [31:0]       ImemData = 32'h0;
  logic              Stall = 1'b0;
  logic              BranchTaken = 1'b0;
  logic [ADDR_W-1:0] BranchTarget = '0;
  logic [31:0]       Instruction;
  logic [ADDR_W-1:0] InstrPC;
  logic              PredTaken;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemReady(ImemReady),
    .ImemValid(ImemValid), .ImemData(ImemData),
    .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Instruction(Instruction), .InstrPC(InstrPC), .PredTaken(PredTaken)
  );

  typedef struct { logic [31:0] word; logic [ADDR_W-1:0] addr; } fent_t;
  typedef struct { logic [ADDR_W-1:0] addr; bit stale; } oent_t;
  typedef struct { logic [ADDR_W-1:0] addr; int due; } ment_t;

  fent_t mq[$];
  oent_t oq[$];
  ment_t memq[$];
  logic [ADDR_W-1:0] m_pc;
  int cyc, last_due, checks, errors;
  bit stall_v, br_v, rdy_v;
  logic [ADDR_W-1:0] tgt_v;
  int lat_min, lat_max;
  logic [31:0] obs_instr;
  logic [ADDR_W-1:0] obs_pc, obs_addr;
  logic obs_req, obs_pred;

  function automatic logic [31:0] mem_word(logic [ADDR_W-1:0] a);
    if (a == BR_ADDR) return BR_WORD;
    return MEM_BASE + 32'(a);
  endfunction

  function automatic bit is_bal(logic [31:0] w);
    return (w[31:28] == 4'b0100) && (w[27:25] == 3'b111);
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: starts and ends at a falling edge.
  task automatic cycle();
    bit pop, br_eff, predict, hs, e_req, e_pred;
    int occ, due;
    logic [31:0] e_instr;
    logic [ADDR_W-1:0] e_pc, tgt;
    oent_t r;
    ment_t m;
    fent_t f;
    Stall        = stall_v;
    BranchTaken  = br_v;
    BranchTarget = tgt_v;
    ImemReady    = rdy_v;
    ImemValid    = 1'b0;
    ImemData     = 32'hDEAD_BEEF;
    if (memq.size() > 0) begin
      if (memq[0].due == cyc) begin
        ImemValid = 1'b1;
        ImemData  = mem_word(memq[0].addr);
      end
    end
    #1;
    e_instr = (mq.size() > 0) ? mq[0].word : 32'h0;
    e_pc    = (mq.size() > 0) ? mq[0].addr : '0;
    e_pred  = PRED_EN && is_bal(e_instr);
    pop     = !stall_v && (mq.size() > 0);
    predict = PRED_EN && pop && is_bal(e_instr);
    br_eff  = br_v || predict;
    tgt     = br_v ? tgt_v : e_instr[ADDR_W-1:0];
    occ     = mq.size() - (pop ? 1 : 0);
    e_req   = ((occ + oq.size()) < 2) && !br_eff;

    obs_instr = Instruction;
    obs_pc    = InstrPC;
    obs_req   = ImemReq;
    obs_addr  = ImemAddr;
    obs_pred  = PredTaken;
    check("Instruction", 64'(obs_instr), 64'(e_instr));
    check("InstrPC", 64'(obs_pc), 64'(e_pc));
    check("ImemReq", 64'(obs_req), 64'(e_req));
    check("ImemAddr", 64'(obs_addr), 64'(m_pc));
    check("PredTaken", 64'(obs_pred), 64'(e_pred));

    hs = e_req && rdy_v;
    if (ImemValid) begin
      r = oq.pop_front();
      m = memq.pop_front();
    end
    if (br_eff) begin
      mq.delete();
      foreach (oq[i]) oq[i].stale = 1'b1;
      m_pc = tgt;
    end else begin
      if (pop) f = mq.pop_front();
      if (ImemValid && !r.stale) begin
        f.word = mem_word(r.addr);
        f.addr = r.addr;
        mq.push_back(f);
      end
    end
    if (hs) begin
      r.addr = m_pc; r.stale = 1'b0;
      oq.push_back(r);
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      m.addr = m_pc; m.due = due;
      memq.push_back(m);
      m_pc = m_pc + 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_Instruction", 64'(Instruction), 64'h0);
    check("rst_InstrPC", 64'(InstrPC), 64'h0);
    check("rst_PredTaken", 64'(PredTaken), 64'h0);
    check("rst_ImemReq", 64'(ImemReq), 64'h0);
    check("rst_ImemAddr", 64'(ImemAddr), 64'h0);
    mq.delete(); oq.delete(); memq.delete();
    m_pc = '0; last_due = 0;
    ImemValid = 1'b0; BranchTaken = 1'b0; Stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] rnd;
    checks = 0; errors = 0; cyc = 0; last_due = 0;
    stall_v = 0; br_v = 0; rdy_v = 1; tgt_v = '0; lat_min = 1; lat_max = 1;
    @(negedge clk);
    do_reset();

    // Straight-line stream from reset with a 1-cycle memory.
    cycle();
    check("first_req", 64'(obs_req), 64'h1);
    check("first_addr", 64'(obs_addr), 64'h0);
    cycle(); cycle();
    check("first_word", 64'(obs_instr), 64'h1000_0000);
    cycle();
    check("second_word", 64'(obs_instr), 64'h1000_0001);

    // Stall while word 2 is at the head.
    stall_v = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("stall_hold", 64'(obs_instr), 64'h1000_0002);
    end
    check("stall_full_noreq", 64'(obs_req), 64'h0);
    stall_v = 0;
    cycle();
    cycle();
    check("resume_w3", 64'(obs_instr), 64'h1000_0003);
    cycle();
    check("resume_w4", 64'(obs_instr), 64'h1000_0004);

    // Redirect with two requests outstanding at 3-cycle latency.
    lat_min = 3; lat_max = 3;
    n = 0;
    while (n < 30 && !(oq.size() == 2 && !(memq.size() > 0 && memq[0].due == cyc))) begin
      cycle(); n++;
    end
    check("two_outstanding_reached", 64'(n < 30), 64'h1);
    br_v = 1; tgt_v = 20'h00100;
    cycle();
    br_v = 0;
    cycle();
    check("redirect_nop", 64'(obs_instr), 64'h0);
    n = 0;
    while (n < 20 && obs_instr == 32'h0) begin cycle(); n++; end
    check("redirect_arrived", 64'(n < 20), 64'h1);
    check("redirect_pc", 64'(obs_pc), 64'h00100);
    check("redirect_word", 64'(obs_instr), 64'h1000_0100);

    // Redirect coincident with a response and Stall.
    lat_min = 1; lat_max = 2;
    n = 0;
    while (n < 30 && !(mq.size() > 0 && memq.size() > 0 && memq[0].due == cyc)) begin
      cycle(); n++;
    end
    check("coinc_setup", 64'(n < 30), 64'h1);
    stall_v = 1; br_v = 1; tgt_v = 20'h00300;
    cycle();
    stall_v = 0; br_v = 0;
    cycle();
    check("coinc_empty_instr", 64'(obs_instr), 64'h0);
    check("coinc_empty_pc", 64'(obs_pc), 64'h0);
    n = 0;
    while (n < 20 && obs_instr == 32'h0) begin cycle(); n++; end
    check("coinc_target_pc", 64'(obs_pc), 64'h00300);

    // PC wrap at the top of the address space.
    lat_min = 1; lat_max = 1;
    br_v = 1; tgt_v = 20'hFFFFF;
    cycle();
    br_v = 0;
    cycle();
    check("wrap_addr_top", 64'(obs_addr), 64'hFFFFF);
    cycle();
    check("wrap_req", 64'(obs_req), 64'h1);
    check("wrap_addr_zero", 64'(obs_addr), 64'h0);

    // Always-taken branch word at BR_ADDR.
    br_v = 1; tgt_v = 20'h001FE;
    cycle();
    br_v = 0;
    n = 0;
    while (n < 20 && !(obs_pc == BR_ADDR && obs_instr != 32'h0)) begin cycle(); n++; end
    check("bal_reached", 64'(n < 20), 64'h1);
    check("bal_word", 64'(obs_instr), 64'(BR_WORD));
    check("bal_pred", 64'(obs_pred), 64'(PRED_EN));
    cycle();
    n = 0;
    while (n < 20 && obs_instr == 32'h0) begin cycle(); n++; end
    check("bal_next_pc", 64'(obs_pc), PRED_EN ? 64'h00040 : 64'h00201);

    // Asynchronous reset in the middle of traffic.
    lat_min = 1; lat_max = 3;
    repeat (6) cycle();
    do_reset();
    cycle(); cycle(); cycle();
    check("post_reset_word", 64'(obs_instr), 64'h0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      stall_v = ($urandom_range(3, 0) == 0);
      rdy_v   = ($urandom_range(3, 0) != 0);
      br_v    = ($urandom_range(39, 0) == 0);
      rnd     = $urandom;
      tgt_v   = rnd[ADDR_W-1:0];
      cycle();
    end
    br_v = 0; stall_v = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

- Instruction-fetch stage for the custom CPU. Produces the 32-bit `Instruction` word consumed by the decode stage.
- Walks a word-addressed PC and issues requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers up to two fetched words and holds the head word while decode asserts `Stall`.
- On a branch redirect it flushes the buffer and discards stale memory responses, so decode sees NOP (32'h0) until the new stream arrives.

## Interface
Parameters:
- ADDR_W, 20, PC / instruction-memory word-address width (matches 20-bit immediate field)
- RESET_PC, 0, PC value loaded at reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ImemReq  out  1  request valid
- ImemAddr  out  ADDR_W  request word address
- ImemReady  in  1  memory accepts request this cycle
- ImemValid  in  1  response valid (in order, latency ≥1, no backpressure)
- ImemData  in  32  response word
- Stall  in  1  decode stall; hold current `Instruction`
- BranchTaken  in  1  single-cycle redirect pulse from execute
- BranchTarget  in  ADDR_W  redirect word address
- Instruction  out  32  word to decode; 32'h0 (NOP) when buffer empty
- InstrPC  out  ADDR_W  address of `Instruction`; 0 when empty
- PredTaken  out  1  fetch already redirected on this instruction (see Configuration)

## Operation
- State:
  - PC register
  - 2-entry FIFO of {word, addr}
  - `Outst` counter, 0..2: accepted requests not yet returned
  - `Drop` counter, 0..2: responses to discard
- Issue rule:
  - `ImemReq` = 1 when occupancy + `Outst` < 2 and `BranchTaken` = 0.
  - `ImemAddr` = PC.
  - On handshake (`ImemReq` & `ImemReady`): PC <= PC+1 mod 2^ADDR_W, wrapping to 0; `Outst`++.
- Response rule:
  - On `ImemValid`, `Outst`-- always.
  - If `Drop` > 0: `Drop`--, word discarded.
  - Otherwise push {ImemData, tag addr}. The tag comes from a 2-deep address queue captured at handshake.
- Output / pop:
  - `Instruction`/`InstrPC` = FIFO head.
  - Pop when `Stall` = 0 and FIFO non-empty.
  - Push and pop in the same cycle are legal.
  - Capacity is never exceeded, guaranteed by the issue rule.
- Redirect (`BranchTaken` = 1):
  - PC <= BranchTarget; FIFO cleared.
  - `Drop` <= `Outst` minus any response arriving this cycle, plus 1 if a handshake completes this cycle (it cannot, since `ImemReq` is low).
  - The `ImemValid` word arriving this cycle is discarded.
  - Redirect overrides `Stall` and a simultaneous pop.
- Overflow of `Outst`/`Drop` is a design error; an assertion checks both stay ≤ 2.

## Timing
- Reset values:
  - PC = RESET_PC; FIFO empty; `Outst` = `Drop` = 0
  - `Instruction` = 32'h0, `InstrPC` = 0, `PredTaken` = 0
  - `ImemReq` = 0 during reset, 1 in the first cycle after release
- With 1-cycle memory:
  - Request in cycle N, response in N+1.
  - The word appears on `Instruction` in N+2.
  - Sustained throughput is 1 instruction/cycle.
- All outputs except `ImemReq`/`ImemAddr` come directly from registers.
- Redirect pulse in cycle R:
  - `Instruction` = 0 from R+1.
  - Request to BranchTarget in R+1.
  - Target word visible at R+3 (1-cycle memory, no stale responses pending).
- Reset asserted mid-operation clears everything immediately. Responses to pre-reset requests are not dropped; the memory is reset together with this block.

## Configuration
- `FETCH_STATIC_PREDICT_EN` defined:
  - When the head pops with opcode [31:28] = 4'b0100 and condition [27:25] = 3'b111 (always), fetch self-redirects to {Instruction[ADDR_W-1:0]} in the next cycle, with the same flush/drop rules as `BranchTaken`.
  - `PredTaken` = 1 alongside that instruction.
  - An external `BranchTaken` in the same cycle wins.
- Undefined: no self-redirect; `PredTaken` tied 0.

## Structure
- Shared CPU package:
  - opcode constants (NOPER = 4'b0000, B = 4'b0100, …)
  - NOP word 32'h0
  - branch-always code 3'b111
- One sub-module: `fetch_fifo`, a 2-entry {32+ADDR_W}-bit FIFO with push/pop/flush and count.

## Test plan
- Reset release, 1-cycle memory returning addr+32'h1000_0000: `ImemAddr` 0,1,2…; `Instruction` 32'h1000_0000 at cycle 3, then increments every cycle.
- `Stall` = 1 for 4 cycles while at word 0x1000_0002: `Instruction` holds; `ImemReq` = 0 once FIFO full; resumes with 0x1000_0003 with no gap or duplicate.
- `BranchTaken` with target 0x00100 while 2 requests outstanding at 3-cycle latency: both stale responses discarded; `Instruction` = 0 until the word from 0x00100 arrives; `InstrPC` = 0x00100.
- `BranchTaken` coincident with `ImemValid` and `Stall` = 1: FIFO empty next cycle, arriving word not pushed, `Drop` = `Outst` − 1.
- PC at 20'hFFFFF: next request address 20'h00000.
- With `FETCH_STATIC_PREDICT_EN`, fetch 32'h4E00_0040 (B always, target 0x40): `PredTaken` = 1 with it, next instruction delivered from 0x40; without the macro, sequential words follow.
